// File: rtl/angle_sweep_gen.sv
// angle_sweep_gen: registered angle sequencer feeding the sine LUT stage.
// A start pulse launches a sweep of COUNT angles (start, start+step, ...),
// each wrapped into 0..ANGLE_MOD-1, delivered over a valid/ready stream.
module angle_sweep_gen #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ANGLE_MOD = 360,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_angle,
  input  logic [WIDTH-1:0] step,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] angle,
  output logic             angle_valid,
  input  logic             angle_ready,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int unsigned SUM_W   = WIDTH + 1;
  localparam logic [SUM_W-1:0] MOD_EXT = SUM_W'(ANGLE_MOD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_angle;
  logic [WIDTH-1:0] w_angle_nxt;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] w_step_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_cfg_err;
  logic             w_cfg_err_nxt;

  logic [SUM_W-1:0] w_sum;
  logic [WIDTH-1:0] w_angle_wrap;
  logic             w_cfg_bad;
  logic             w_xfer;

  // Next angle with a single conditional subtract; step < ANGLE_MOD keeps sum < 2*ANGLE_MOD
  always_comb begin
    w_sum        = {1'b0, r_angle} + {1'b0, r_step};
    w_angle_wrap = (w_sum >= MOD_EXT) ? WIDTH'(w_sum - MOD_EXT) : WIDTH'(w_sum);
    w_cfg_bad    = ({1'b0, start_angle} >= MOD_EXT) || ({1'b0, step} >= MOD_EXT);
    w_xfer       = r_valid && angle_ready;
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_angle_nxt     = r_angle;
    w_step_nxt      = r_step;
    w_remaining_nxt = r_remaining;
    w_valid_nxt     = r_valid;
    w_last_nxt      = r_last;
    w_cfg_err_nxt   = r_cfg_err;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_bad) begin
            w_cfg_err_nxt = 1'b1;
          end else begin
            w_cfg_err_nxt = 1'b0;
            if (count == '0) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_state_nxt     = S_RUN;
              w_step_nxt      = step;
              w_remaining_nxt = count;
              w_angle_nxt     = start_angle;
              w_valid_nxt     = 1'b1;
              w_last_nxt      = (count == CNT_W'(1));
            end
          end
        end
      end
      S_RUN: begin
        if (w_xfer) begin
          if (r_remaining > CNT_W'(1)) begin
            w_remaining_nxt = r_remaining - CNT_W'(1);
            w_angle_nxt     = w_angle_wrap;
            w_last_nxt      = (r_remaining == CNT_W'(2));
          end else begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_FINISH);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_angle     <= '0;
      r_step      <= '0;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_angle     <= w_angle_nxt;
      r_step      <= w_step_nxt;
      r_remaining <= w_remaining_nxt;
      r_valid     <= w_valid_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
    end
  end

  assign angle       = r_angle;
  assign angle_valid = r_valid;
  assign last        = r_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_angle_sweep_gen.sv
// Directed bench for angle_sweep_gen with a scoreboard of expected angles.
module tb_angle_sweep_gen;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] angle;
    logic             last;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] start_angle;
  logic [WIDTH-1:0] step;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] angle;
  logic             angle_valid;
  logic             angle_ready;
  logic             last;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] held_angle = '0;
  logic             held_last  = 1'b0;

  angle_sweep_gen #(.WIDTH(WIDTH), .ANGLE_MOD(360), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_angle (start_angle),
    .step        (step),
    .count       (count),
    .angle       (angle),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .last        (last),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int unsigned a, input bit l);
    exp_t e;
    e.angle = WIDTH'(a);
    e.last  = l;
    return e;
  endfunction

  // Reference sweep: successive angles wrapped into 0..359
  task automatic push_sweep(input int unsigned sa, input int unsigned st, input int unsigned cnt);
    int unsigned a;
    a = sa;
    for (int unsigned i = 0; i < cnt; i++) begin
      sb.push_back(mk(a, i == cnt - 1));
      a = a + st;
      if (a >= 360) a = a - 360;
    end
  endtask

  task automatic do_start(input int unsigned sa, input int unsigned st, input int unsigned cnt);
    start       = 1'b1;
    start_angle = WIDTH'(sa);
    step        = WIDTH'(st);
    count       = CNT_W'(cnt);
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < max);
    chk(tag, 64'(done), 64'd1);
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks stall hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_angle", 64'(angle), 64'(held_angle));
        chk("hold_valid", 64'(angle_valid), 64'd1);
        chk("hold_last", 64'(last), 64'(held_last));
      end
      if (angle_valid && angle_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("angle", 64'(angle), 64'(e.angle));
          chk("last", 64'(last), 64'(e.last));
        end
      end
      prev_stall = angle_valid && !angle_ready;
      held_angle = angle;
      held_last  = last;
    end
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_angle = '0;
    step        = '0;
    count       = '0;
    angle_ready = 1'b1;
    tick();
    tick();
    chk("rst_angle", 64'(angle), 64'd0);
    chk("rst_valid", 64'(angle_valid), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: wrapping sweep with no backpressure
    sb.push_back(mk(350, 1'b0));
    sb.push_back(mk(357, 1'b0));
    sb.push_back(mk(4, 1'b0));
    sb.push_back(mk(11, 1'b1));
    do_start(350, 7, 4);
    chk("t1_valid_latency", 64'(angle_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done", 20, n);
    chk("t1_done_cycles", 64'(n), 64'd4);
    chk("t1_busy_at_done", 64'(busy), 64'd1);
    chk("t1_valid_at_done", 64'(angle_valid), 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // 2: backpressure pattern 1,0,0,1,...
    sb.push_back(mk(0, 1'b0));
    sb.push_back(mk(90, 1'b0));
    sb.push_back(mk(180, 1'b0));
    sb.push_back(mk(270, 1'b0));
    sb.push_back(mk(0, 1'b1));
    do_start(0, 90, 5);
    n = 0;
    do begin
      angle_ready = (n % 3 == 0);
      tick();
      n++;
    end while (!done && n < 60);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    angle_ready = 1'b1;
    tick();

    // 3: legal start with zero count
    do_start(10, 20, 0);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_valid", 64'(angle_valid), 64'd0);
    tick();
    chk("t3_busy_off", 64'(busy), 64'd0);
    chk("t3_done_off", 64'(done), 64'd0);

    // 4: illegal configs, then a recovering legal start
    do_start(400, 10, 3);
    chk("t4_cfg_err_angle", 64'(cfg_err), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    tick();
    chk("t4_valid", 64'(angle_valid), 64'd0);
    do_start(10, 360, 2);
    chk("t4_cfg_err_step", 64'(cfg_err), 64'd1);
    chk("t4_busy2", 64'(busy), 64'd0);
    push_sweep(20, 100, 3);
    do_start(20, 100, 3);
    chk("t4_cfg_err_clr", 64'(cfg_err), 64'd0);
    wait_done("t4_done", 20, n);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // 5: reset during the second sample of a 6-sample sweep
    push_sweep(100, 50, 6);
    do_start(100, 50, 6);
    tick();
    chk("t5_second", 64'(angle), 64'd150);
    rst_n = 1'b0;
    sb.delete();
    tick();
    chk("t5_rst_angle", 64'(angle), 64'd0);
    chk("t5_rst_valid", 64'(angle_valid), 64'd0);
    chk("t5_rst_last", 64'(last), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t5_no_done", 64'(done), 64'd0);
    push_sweep(5, 355, 3);
    do_start(5, 355, 3);
    wait_done("t5_fresh_done", 20, n);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // 6: start re-pulsed mid-run is ignored; start in FINISH is ignored
    push_sweep(30, 40, 4);
    do_start(30, 40, 4);
    do_start(200, 1, 9);
    wait_done("t6_done", 20, n);
    start       = 1'b1;
    start_angle = WIDTH'(0);
    step        = WIDTH'(1);
    count       = CNT_W'(2);
    tick();
    start = 1'b0;
    chk("t6_finish_start_busy", 64'(busy), 64'd0);
    chk("t6_finish_start_valid", 64'(angle_valid), 64'd0);
    tick();
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
